uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver; successor to the fixed 8-bit, fixed-rate receiver.
- Baud divisor, data length (5–8 bits), parity and stop-bit count are set per frame.
- Detects false starts, framing errors and line break.
- Sits behind the APB register block: config ports are driven from CSRs; outputs feed the RX FIFO and the interrupt logic.

---
 rtl/uart_rx_cfg.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional parity, 1-2 stop bits, break detect.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit sample as a 2-of-3 vote ending on the tick cycle.
module uart_rx_cfg #(
  parameter int DivWidth   = 16,
  parameter int SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                rx_i,
  input  logic [DivWidth-1:0] baud_div_i,
  input  logic [1:0]          data_bits_i,
  input  logic                parity_en_i,
  input  logic                parity_type_i,
  input  logic                stop_bits_i,
  output logic [7:0]          data_o,
  output logic                data_valid_o,
  output logic                parity_error_o,
  output logic                frame_error_o,
  output logic                break_o,
  output logic                busy_o
);
  localparam int Sync = (SyncStages < 2) ? 2 : SyncStages;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_e;

  state_e              state_q, state_d;
  logic [Sync-1:0]     sync_q;
  logic                rx_s, rx_prev_q, sample, tick;
  logic [DivWidth-1:0] cnt_q, cnt_d, div_q, div_d, div_clamped;
  logic [2:0]          idx_q, idx_d, last_q, last_d;
  logic                par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [7:0]          data_q, data_d;
  logic                par_acc_q, par_acc_d, perr_q, perr_d, zero_q, zero_d;
  logic                dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;

  assign rx_s        = sync_q[Sync-1];
  assign div_clamped = (baud_div_i < DivWidth'(4)) ? DivWidth'(4) : baud_div_i;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end
  assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s;
`endif

  // START samples at mid-bit; every later bit is a full period on from there.
  assign tick = (state_q == START) ? (cnt_q == (div_q >> 1) - DivWidth'(1))
                                   : (cnt_q == div_q - DivWidth'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DivWidth'(1);
    div_d     = div_q;
    idx_d     = idx_q;
    last_d    = last_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    data_d    = data_q;
    par_acc_d = par_acc_q;
    perr_d    = perr_q;
    zero_d    = zero_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    brk_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d   = START;
          div_d     = div_clamped;
          last_d    = {1'b1, data_bits_i};
          par_en_d  = parity_en_i;
          par_odd_d = parity_type_i;
          stop2_d   = stop_bits_i;
          idx_d     = '0;
          par_acc_d = 1'b0;
          perr_d    = 1'b0;
          zero_d    = 1'b1;
          for (int i = 0; i < 8; i++)
            if (i > int'(last_d)) data_d[i] = 1'b0;
        end
      end
      START: if (tick) begin
        cnt_d   = '0;
        state_d = sample ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d         = '0;
        data_d[idx_q] = sample;
        par_acc_d     = par_acc_q ^ sample;
        if (sample) zero_d = 1'b0;
        if (idx_q == last_q) state_d = par_en_q ? PARITY : STOP1;
        else                 idx_d   = idx_q + 3'd1;
      end
      PARITY: if (tick) begin
        cnt_d   = '0;
        perr_d  = sample ^ par_acc_q ^ par_odd_q;
        if (sample) zero_d = 1'b0;
        state_d = STOP1;
      end
      STOP1: if (tick) begin
        cnt_d = '0;
        if (stop2_q && sample) begin
          state_d = STOP2;
        end else if (!sample && zero_q) begin
          brk_d   = 1'b1;
          fe_d    = 1'b1;
          state_d = WAIT_HIGH;
        end else begin
          dv_d    = 1'b1;
          pe_d    = perr_q & par_en_q;
          fe_d    = !sample;
          state_d = sample ? IDLE : WAIT_HIGH;
        end
      end
      STOP2: if (tick) begin
        cnt_d   = '0;
        dv_d    = 1'b1;
        pe_d    = perr_q & par_en_q;
        fe_d    = !sample;
        state_d = sample ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      div_q     <= DivWidth'(4);
      idx_q     <= '0;
      last_q    <= 3'd7;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
      zero_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[Sync-2:0], rx_i};
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      data_q    <= data_d;
      par_acc_q <= par_acc_d;
      perr_q    <= perr_d;
      zero_q    <= zero_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = dv_q;
  assign parity_error_o = pe_q;
  assign frame_error_o  = fe_q;
  assign break_o        = brk_q;
  assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame-level model predicts each pulse (fields and cycle).
module tb_uart_rx_cfg;
  logic        clk = 1'b0;
  logic        arst_i, rx_i;
  logic [15:0] baud_div_i;
  logic [1:0]  data_bits_i;
  logic        parity_en_i, parity_type_i, stop_bits_i;
  logic [7:0]  data_o;
  logic        data_valid_o, parity_error_o, frame_error_o, break_o, busy_o;

  uart_rx_cfg #(.DivWidth(16), .SyncStages(2)) dut (
    .clk_i(clk), .arst_i(arst_i), .rx_i(rx_i), .baud_div_i(baud_div_i),
    .data_bits_i(data_bits_i), .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
    .stop_bits_i(stop_bits_i), .data_o(data_o), .data_valid_o(data_valid_o),
    .parity_error_o(parity_error_o), .frame_error_o(frame_error_o), .break_o(break_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         dv, pe, fe, brk;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0, fails = 0, cyc = 0, t_start = 0;
  int   got_cyc = 0;
  logic [7:0] got_data = '0;
  bit   got_dv = 0, got_pe = 0, got_fe = 0, got_brk = 0;

  // Two sync flops plus the edge-detect register before START is entered.
  localparam int LAT = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input int nb, input bit pen, input bit ptype,
                                 input bit pbit, input bit two, input bit s1, input bit s2);
    exp_t r;
    logic [7:0] m, dd;
    m      = 8'hFF;
    dd     = d & (m >> (8 - nb));
    r.brk  = (dd == 8'h00) && !(pen && pbit) && !s1;
    r.dv   = !r.brk;
    r.data = dd;
    r.pe   = r.dv && pen && ((^dd ^ pbit) != ptype);
    r.fe   = !s1 || (two && !s2);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic drive(input logic lvl, input int n);
    rx_i = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit ptype,
                            input bit pbit, input bit two, input bit s1, input bit s2,
                            input int cfg_div, input int ldiv);
    exp_t x;
    baud_div_i    = 16'(cfg_div);
    data_bits_i   = 2'(nb - 5);
    parity_en_i   = pen;
    parity_type_i = ptype;
    stop_bits_i   = two;
    x     = model(d, nb, pen, ptype, pbit, two, s1, s2);
    x.cyc = cyc + LAT + ldiv / 2 + ldiv * (nb + int'(pen) + 1 + ((two && s1) ? 1 : 0));
    exp_q.push_back(x);
    t_start = cyc;
    drive(1'b0, ldiv);
    // Config is latched at the start edge; disturbing it now must not matter.
    data_bits_i   = ~data_bits_i;
    parity_en_i   = ~parity_en_i;
    parity_type_i = ~parity_type_i;
    stop_bits_i   = ~stop_bits_i;
    baud_div_i    = baud_div_i + 16'd5;
    for (int i = 0; i < nb; i++) drive(d[i], ldiv);
    if (pen) drive(pbit, ldiv);
    drive(s1, ldiv);
    if (two) drive(s2, ldiv);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected pulses missing, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!arst_i) begin
      if (data_valid_o || break_o) begin
        got_cyc  = cyc;
        got_data = data_o;
        got_dv   = data_valid_o;
        got_pe   = parity_error_o;
        got_fe   = frame_error_o;
        got_brk  = break_o;
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data_valid", data_valid_o, e.dv);
          chk("break", break_o, e.brk);
          chk("parity_error", parity_error_o, e.pe);
          chk("frame_error", frame_error_o, e.fe);
          if (e.dv) chk("data", data_o, e.data);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end else begin
        chk("flags_qualified", {parity_error_o, frame_error_o}, 2'b00);
      end
    end
  end

  initial begin
    arst_i = 1'b1; rx_i = 1'b1; baud_div_i = 16'd16; data_bits_i = 2'd3;
    parity_en_i = 1'b0; parity_type_i = 1'b0; stop_bits_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", data_valid_o, 1'b0);
    chk("rst_perr", parity_error_o, 1'b0);
    chk("rst_ferr", frame_error_o, 1'b0);
    chk("rst_break", break_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    arst_i = 1'b0;
    drive(1'b1, 8);

    // 8N1 div 16
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, 16, 16);
    wait_done("8n1_a5");
    chk("lit_a5_data", got_data, 8'hA5);
    chk("lit_a5_latency", got_cyc - t_start, 155);

    // 7O1: wrong then right parity bit
    send_frame(8'h41, 7, 1, 1, 0, 0, 1, 1, 16, 16);
    wait_done("7o1_bad");
    chk("lit_7o1_pe_bad", got_pe, 1'b1);
    chk("lit_7o1_data", got_data, 8'h41);
    send_frame(8'h41, 7, 1, 1, 1, 0, 1, 1, 16, 16);
    wait_done("7o1_good");
    chk("lit_7o1_pe_good", got_pe, 1'b0);

    // 5N2 div 4, back to back
    send_frame(8'h1F, 5, 0, 0, 0, 1, 1, 1, 4, 4);
    send_frame(8'h0A, 5, 0, 0, 0, 1, 1, 1, 4, 4);
    wait_done("5n2_b2b");
    chk("lit_5n2_data", got_data, 8'h0A);
    chk("lit_5n2_latency", got_cyc - t_start, 33);

    // divisor below 4 clamps to 4
    drive(1'b1, 4);
    send_frame(8'h15, 5, 0, 0, 0, 0, 1, 1, 0, 4);
    wait_done("clamp_div");

    // 6E2 div 8
    drive(1'b1, 4);
    send_frame(8'h2D, 6, 1, 0, 0, 1, 1, 1, 8, 8);
    wait_done("6e2");

    // stop bit low, line stays low for a while
    drive(1'b1, 8);
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 1, 16, 16);
    wait_done("stop_err");
    chk("lit_stoperr_fe", got_fe, 1'b1);
    chk("lit_stoperr_dv", got_dv, 1'b1);
    drive(1'b0, 20);
    chk("busy_wait_high", busy_o, 1'b1);
    drive(1'b1, 6);
    chk("busy_after_high", busy_o, 1'b0);

    // break: two frames of low line
    send_frame(8'h00, 8, 0, 0, 0, 0, 0, 0, 16, 16);
    drive(1'b0, 160);
    wait_done("break");
    chk("lit_break", got_brk, 1'b1);
    chk("lit_break_dv", got_dv, 1'b0);
    chk("busy_in_break", busy_o, 1'b1);
    drive(1'b1, 32);
    send_frame(8'h55, 8, 0, 0, 0, 0, 1, 1, 16, 16);
    wait_done("after_break");
    chk("lit_55_data", got_data, 8'h55);

    // 3-cycle glitch is a false start
    baud_div_i = 16'd16; data_bits_i = 2'd3; parity_en_i = 1'b0; stop_bits_i = 1'b0;
    drive(1'b0, 3);
    chk("glitch_busy", busy_o, 1'b1);
    drive(1'b1, 30);
    chk("glitch_idle", busy_o, 1'b0);

    // reset in the middle of the data bits
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    arst_i = 1'b1;
    rx_i   = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_valid", data_valid_o, 1'b0);
    chk("mid_rst_data", data_o, 8'h00);
    arst_i = 1'b0;
    drive(1'b1, 10);
    chk("post_rst_idle", busy_o, 1'b0);
    send_frame(8'h96, 8, 0, 0, 0, 0, 1, 1, 16, 16);
    wait_done("post_rst");
    chk("lit_96_data", got_data, 8'h96);

    drive(1'b1, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
